// File: rtl/wallace_mul_pipe.sv
// rtl/wallace_mul_pipe.sv - two-stage radix-4 Booth / Wallace-tree pipelined multiplier
//
// Shared MUL unit: signed or unsigned WIDTH x WIDTH -> 2*WIDTH product with
// valid/ready handshake on both sides and a tag sideband.
// Stage 1 does Booth encoding and the first ceil(L/2) carry-save levels.
// Stage 2 does the remaining levels plus the carry-propagate adder.
//
// Ports:
//   mul_clk, reset              clock, asynchronous active-high reset
//   flush                       (only with MUL_FLUSH_EN) kill all in-flight ops
//   in_valid/in_ready           request handshake
//   in_signed, in_x, in_y       operands (both signed when in_signed=1)
//   in_tag                      sideband returned with the result
//   out_valid/out_ready         result handshake
//   out_result, out_tag         full product and its tag
//   busy                        any stage holds a valid operation
//
// Optional feature macro: MUL_FLUSH_EN (adds the flush input).
module wallace_mul_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic               mul_clk,
    input  logic               reset,
`ifdef MUL_FLUSH_EN
    input  logic               flush,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   in_x,
    input  logic [WIDTH-1:0]   in_y,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_result,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);
    localparam int P   = 2 * WIDTH;
    localparam int NPP = WIDTH / 2 + 1;
    localparam int EW  = WIDTH + 2;

    function automatic int next_rows(input int n);
        return (n / 3) * 2 + n % 3;
    endfunction

    function automatic int rows_at(input int lv);
        int n;
        n = NPP;
        for (int i = 0; i < lv; i++) n = next_rows(n);
        return n;
    endfunction

    function automatic int count_levels();
        int n;
        int l;
        n = NPP;
        l = 0;
        while (n > 2) begin
            n = next_rows(n);
            l++;
        end
        return l;
    endfunction

    localparam int NLVL = count_levels();
    localparam int CUT  = (NLVL + 1) / 2;
    localparam int NC   = rows_at(CUT);

    logic flush_w;
`ifdef MUL_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Handshake
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_adv, s2_adv, s1_load, s2_load;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv && !flush_w;
    assign s1_load  = in_valid && in_ready;
    assign s2_load  = s1_valid_q && s2_adv;

    always_comb begin
        s1_valid_d = s1_adv ? s1_load : s1_valid_q;
        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
        if (flush_w) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    // Booth partial products. Operands get two extra bits so unsigned values
    // stay positive under the signed radix-4 recoding.
    logic [EW-1:0] x_ext, y_ext;
    logic [P-1:0]  x_p;
    assign x_ext = in_signed ? {{2{in_x[WIDTH-1]}}, in_x} : {2'b00, in_x};
    assign y_ext = in_signed ? {{2{in_y[WIDTH-1]}}, in_y} : {2'b00, in_y};
    assign x_p   = {{(P-EW){x_ext[EW-1]}}, x_ext};

    // lvl[k] holds the rows after k carry-save levels; unused slots are zero.
    logic [P-1:0] lvl [0:NLVL][0:NPP-1];
    logic [P-1:0] tin [0:NLVL-1][0:NPP-1];
    logic [P-1:0] rows_q [0:NC-1];

    for (genvar i = 0; i < NPP; i++) begin : g_booth
        logic [2:0]   grp;
        logic [P-1:0] mag;
        logic [P-1:0] pp;
        if (i == 0) begin : g_first
            assign grp = {y_ext[1:0], 1'b0};
        end else begin : g_rest
            assign grp = y_ext[2*i+1 : 2*i-1];
        end
        always_comb begin
            case (grp)
                3'b001, 3'b010, 3'b101, 3'b110: mag = x_p;
                3'b011, 3'b100:                 mag = x_p << 1;
                default:                        mag = '0;
            endcase
            pp = grp[2] ? (~mag + P'(1)) : mag;
        end
        assign lvl[0][i] = pp << (2 * i);
    end

    // Wallace levels: rows grouped in threes through 3:2 compressors, leftovers
    // pass straight through. Level CUT reads the pipeline registers instead.
    for (genvar lv = 0; lv < NLVL; lv++) begin : g_lvl
        localparam int N = rows_at(lv);
        localparam int G = N / 3;
        localparam int R = N % 3;
        for (genvar r = 0; r < NPP; r++) begin : g_src
            if (lv == CUT) begin : g_reg
                if (r < NC) begin : g_live
                    assign tin[lv][r] = rows_q[r];
                end else begin : g_dead
                    assign tin[lv][r] = '0;
                end
            end else begin : g_comb
                assign tin[lv][r] = lvl[lv][r];
            end
        end
        for (genvar g = 0; g < G; g++) begin : g_csa
            logic [P-1:0] a, b, c;
            assign a = tin[lv][3*g];
            assign b = tin[lv][3*g+1];
            assign c = tin[lv][3*g+2];
            assign lvl[lv+1][2*g]   = a ^ b ^ c;
            assign lvl[lv+1][2*g+1] = ((a & b) | (a & c) | (b & c)) << 1;
        end
        for (genvar r = 0; r < R; r++) begin : g_pass
            assign lvl[lv+1][2*G+r] = tin[lv][3*G+r];
        end
        for (genvar r = 2*G+R; r < NPP; r++) begin : g_zero
            assign lvl[lv+1][r] = '0;
        end
    end

    // Final carry-propagate adder. With a single tree level the whole tree
    // sits in stage 1 and stage 2 is only the adder.
    logic [P-1:0] sum_w;
    if (CUT == NLVL) begin : g_fin_reg
        assign sum_w = rows_q[0] + rows_q[1];
    end else begin : g_fin_tree
        assign sum_w = lvl[NLVL][0] + lvl[NLVL][1];
    end

    logic [TAG_W-1:0] tag1_q, tag2_q;
    logic [P-1:0]     result_q;

    always_ff @(posedge mul_clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            tag1_q     <= '0;
            tag2_q     <= '0;
            result_q   <= '0;
            for (int r = 0; r < NC; r++) rows_q[r] <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (s1_load) begin
                for (int r = 0; r < NC; r++) rows_q[r] <= lvl[CUT][r];
                tag1_q <= in_tag;
            end
            if (s2_load) begin
                result_q <= sum_w;
                tag2_q   <= tag1_q;
            end
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_result = result_q;
    assign out_tag    = tag2_q;
    assign busy       = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_wallace_mul_pipe.sv
// tb/tb_wallace_mul_pipe.sv - self-checking bench for wallace_mul_pipe
module tb_wallace_mul_pipe;
    logic        mul_clk = 1'b0;
    logic        reset = 1'b0;
`ifdef MUL_FLUSH_EN
    logic        flush = 1'b0;
`endif
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_signed = 1'b0;
    logic [31:0] in_x = '0;
    logic [31:0] in_y = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_result;
    logic [4:0]  out_tag;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int retired = 0;

    typedef struct packed {
        logic [4:0]  tag;
        logic [63:0] res;
    } exp_t;
    exp_t exp_q[$];

    wallace_mul_pipe #(.WIDTH(32), .TAG_W(5)) dut (
        .mul_clk    (mul_clk),
        .reset      (reset),
`ifdef MUL_FLUSH_EN
        .flush      (flush),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_signed  (in_signed),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    always #5 mul_clk = ~mul_clk;

    // Exact product of the extended operands, truncated to 64 bits.
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] ex, ey;
        ex = sgn ? {{32{x[31]}}, x} : {32'd0, x};
        ey = sgn ? {{32{y[31]}}, y} : {32'd0, y};
        return ex * ey;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge mul_clk);
        @(negedge mul_clk);
    endtask

    task automatic rand_op(input logic [4:0] tag);
        in_signed = 1'($urandom_range(0, 1));
        in_x      = pick();
        in_y      = pick();
        in_tag    = tag;
    endtask

    // Called once inputs for the coming edge have settled; scores the retire
    // and accept that this edge will perform, then advances one cycle.
    task automatic sb_step();
        exp_t e;
        if (out_valid && out_ready) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL sb_extra: observed=result tag %0d expected=no result", out_tag);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_result", out_result, e.res);
                chk("sb_tag", 64'(out_tag), 64'(e.tag));
                retired++;
            end
        end
        if (in_valid && in_ready) begin
            e.tag = in_tag;
            e.res = model(in_signed, in_x, in_y);
            exp_q.push_back(e);
        end
        tick();
    endtask

    task automatic run_single(input logic sgn, input logic [31:0] x, input logic [31:0] y,
                              input logic [4:0] tag, input logic [63:0] expv);
        in_valid = 1'b1; in_signed = sgn; in_x = x; in_y = y; in_tag = tag;
        out_ready = 1'b1;
        #1;
        chk("single_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("single_lat1_valid", 64'(out_valid), 64'd0);
        tick();
        #1;
        chk("single_lat2_valid", 64'(out_valid), 64'd1);
        chk("single_result", out_result, expv);
        chk("single_tag", 64'(out_tag), 64'(tag));
        tick();
        #1;
        chk("single_retired", 64'(out_valid), 64'd0);
    endtask

    initial begin
        // Reset state
        #1 reset = 1'b1;
        @(negedge mul_clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_result", out_result, 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge mul_clk);
        reset = 1'b0;

        // Directed corner products
        run_single(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 64'h0000_0000_0000_0001);
        run_single(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 64'hFFFF_FFFE_0000_0001);
        run_single(1'b1, 32'h8000_0000, 32'h8000_0000, 5'd5, 64'h4000_0000_0000_0000);
        run_single(1'b1, 32'h8000_0000, 32'h0000_0001, 5'd6, 64'hFFFF_FFFF_8000_0000);
        run_single(1'b0, 32'h8000_0000, 32'h8000_0000, 5'd7, 64'h4000_0000_0000_0000);

        // Back-to-back stream of 8, results every cycle from the second edge on
        retired = 0;
        for (int i = 0; i < 12; i++) begin
            in_valid = (i < 8);
            if (i < 8) rand_op(5'(i));
            out_ready = 1'b1;
            #1;
            chk("stream_in_ready", 64'(in_ready), 64'd1);
            chk("stream_out_valid", 64'(out_valid), 64'((i >= 2) && (i < 10)));
            sb_step();
        end
        chk("stream_retired", 64'(retired), 64'd8);
        chk("stream_drained", 64'(exp_q.size()), 64'd0);

        // Random traffic with random backpressure
        retired = 0;
        for (int i = 0; i < 60; i++) begin
            in_valid  = 1'($urandom_range(0, 3) != 0);
            rand_op(5'($urandom()));
            out_ready = 1'($urandom_range(0, 2) != 0);
            #1;
            sb_step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            sb_step();
        end
        chk("random_drained", 64'(exp_q.size()), 64'd0);
        chk("random_idle", 64'(busy), 64'd0);

        // Backpressure: two accepts fill the pipe, then everything holds
        in_valid = 1'b1;
        out_ready = 1'b0;
        rand_op(5'd10);
        #1;
        chk("bp_ready0", 64'(in_ready), 64'd1);
        sb_step();
        rand_op(5'd11);
        #1;
        chk("bp_ready1", 64'(in_ready), 64'd1);
        sb_step();
        for (int i = 0; i < 3; i++) begin
            rand_op(5'(12 + i));
            #1;
            chk("bp_stalled_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_result", out_result, exp_q[0].res);
            chk("bp_hold_tag", 64'(out_tag), 64'(exp_q[0].tag));
            sb_step();
        end
        rand_op(5'd20);
        out_ready = 1'b1;
        #1;
        chk("bp_resume_ready", 64'(in_ready), 64'd1);
        sb_step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            sb_step();
        end
        chk("bp_drained", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset with both stages full
        in_valid = 1'b1;
        out_ready = 1'b0;
        rand_op(5'd21);
        #1;
        sb_step();
        rand_op(5'd22);
        #1;
        sb_step();
        in_valid = 1'b0;
        #1;
        chk("rst_mid_full_valid", 64'(out_valid), 64'd1);
        chk("rst_mid_full_busy", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_valid", 64'(out_valid), 64'd0);
        chk("rst_async_busy", 64'(busy), 64'd0);
        chk("rst_async_result", out_result, 64'd0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rst_after_idle", 64'(out_valid), 64'd0);
            tick();
        end

`ifdef MUL_FLUSH_EN
        // Flush kills both in-flight ops; the next accept is unaffected
        out_ready = 1'b0;
        in_valid = 1'b1;
        rand_op(5'd1);
        tick();
        rand_op(5'd2);
        tick();
        flush = 1'b1;
        rand_op(5'd7);
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("flush_out_valid", 64'(out_valid), 64'd0);
            chk("flush_busy", 64'(busy), 64'd0);
            tick();
        end
        in_x = pick();
        in_y = pick();
        run_single(1'b1, in_x, in_y, 5'd9, model(1'b1, in_x, in_y));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
